// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared load/store encodings and data-memory sequencer state type
package cpu_pkg;

    // RV32 load/store funct3 encodings (stores reuse the load size codes)
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Active-low byte enables with no lane selected (reads / idle)
    localparam logic [3:0] WEB_NONE = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } dm_state_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and sign/zero-extends load data from a memory word
//
// Ports:
//   funct3   in  3   load funct3 (LB/LH/LW/LBU/LHU, others = full word)
//   byte_off in  2   byte offset of the access inside the word
//   rdata    in  32  word returned by the data memory
//   ext_data out 32  aligned, extended load result
module load_align
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{byte_off, 3'b000} +: 8];
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
        ext_data = rdata;
        case (funct3)
            LB:      ext_data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     ext_data = {24'h000000, byte_sel};
            LH:      ext_data = {{16{half_sel[15]}}, half_sel};
            LHU:     ext_data = {16'h0000, half_sel};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - MEM-stage load/store sequencer for a req/gnt/rvalid data memory
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   mem_valid, mem_we, funct3  MEM-stage access request, direction and size
//   addr, st_web, st_wdata     byte address and formatted store lanes/data
//   stall                      holds IF/ID/EX/MEM while the access is in flight
//   ld_data, ld_valid          extended load result and its one-cycle update pulse
//   misalign_exc               one-cycle pulse when an access is rejected
//   dm_req/dm_gnt              memory request handshake
//   dm_addr/dm_web/dm_wdata    word address, active-low byte enables, store data
//   dm_rvalid/dm_rdata         memory read response
module dm_access_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        st_web,
    input  logic [DATA_W-1:0] st_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_valid,
    output logic              misalign_exc,
    output logic              dm_req,
    input  logic              dm_gnt,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_web,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_rvalid,
    input  logic [DATA_W-1:0] dm_rdata
);

    dm_state_t   state, state_next;
    logic        cap_we;
    logic [2:0]  cap_funct3;
    logic [1:0]  cap_off;
    logic        accept;
    logic        misaligned;
    logic        store_noop;
    logic [31:0] ext_data;

    assign accept     = (state == IDLE) && mem_valid;
    assign misaligned = (((funct3 == LH) || (funct3 == LHU)) && addr[0]) ||
                        ((funct3 == LW) && (addr[1:0] != 2'b00));
    // A store whose formatter enabled no lanes has nothing to write.
    assign store_noop = mem_we && (st_web == WEB_NONE);

    assign stall = accept || (state == REQ) || (state == RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    if (misaligned || store_noop) state_next = DONE;
                    else                          state_next = REQ;
                end
            end
            REQ:     if (dm_gnt)    state_next = cap_we ? DONE : RESP;
            RESP:    if (dm_rvalid) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    load_align u_load_align (
        .funct3   (cap_funct3),
        .byte_off (cap_off),
        .rdata    (dm_rdata),
        .ext_data (ext_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dm_req       <= 1'b0;
            dm_addr      <= '0;
            dm_web       <= WEB_NONE;
            dm_wdata     <= '0;
            ld_data      <= '0;
            ld_valid     <= 1'b0;
            misalign_exc <= 1'b0;
            cap_we       <= 1'b0;
            cap_funct3   <= 3'b000;
            cap_off      <= 2'b00;
        end else begin
            // dm_req mirrors residence in REQ, so it drops the cycle after gnt.
            dm_req       <= (state_next == REQ);
            misalign_exc <= accept && misaligned;
            ld_valid     <= (state == RESP) && dm_rvalid;
            if (accept) begin
                cap_we     <= mem_we;
                cap_funct3 <= funct3;
                cap_off    <= addr[1:0];
            end
            // Port fields only change when a new request is launched, so they
            // stay stable for the whole REQ phase regardless of pipeline inputs.
            if (accept && (state_next == REQ)) begin
                dm_addr  <= {addr[ADDR_W-1:2], 2'b00};
                dm_web   <= mem_we ? st_web : WEB_NONE;
                dm_wdata <= mem_we ? st_wdata : '0;
            end
            if ((state == RESP) && dm_rvalid) ld_data <= ext_data;
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// tb/tb_dm_access_unit.sv - directed self-checking bench for dm_access_unit
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [3:0]  st_web;
    logic [31:0] st_wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        misalign_exc;
    logic        dm_req;
    logic        dm_gnt;
    logic [31:0] dm_addr;
    logic [3:0]  dm_web;
    logic [31:0] dm_wdata;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    int checks = 0;
    int errors = 0;
    int ld_valid_cnt = 0;
    int grant_cnt = 0;

    always #5 clk = ~clk;

    dm_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_valid    (mem_valid),
        .mem_we       (mem_we),
        .funct3       (funct3),
        .addr         (addr),
        .st_web       (st_web),
        .st_wdata     (st_wdata),
        .stall        (stall),
        .ld_data      (ld_data),
        .ld_valid     (ld_valid),
        .misalign_exc (misalign_exc),
        .dm_req       (dm_req),
        .dm_gnt       (dm_gnt),
        .dm_addr      (dm_addr),
        .dm_web       (dm_web),
        .dm_wdata     (dm_wdata),
        .dm_rvalid    (dm_rvalid),
        .dm_rdata     (dm_rdata)
    );

    always @(negedge clk) begin
        if (ld_valid) ld_valid_cnt++;
        if (dm_req && dm_gnt) grant_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one MEM-stage access and plays memory. gnt is given on REQ cycle
    // gnt_wait+1, rvalid on RESP cycle rv_wait+1. Returns after the DONE cycle
    // with mem_valid still high (it must not be re-sampled in DONE).
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [3:0] web, input logic [31:0] wd,
                             input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                             output int stall_cyc, output int req_cyc, output int req_bad,
                             output logic done_lv, output logic done_mx, output logic done_to);
        int  resp_cyc;
        bit  in_resp;
        logic [31:0] exp_addr;
        logic [3:0]  exp_web;
        stall_cyc = 0; req_cyc = 0; req_bad = 0; resp_cyc = 0; in_resp = 0;
        done_lv = 0; done_mx = 0; done_to = 1;
        exp_addr = {a[31:2], 2'b00};
        exp_web  = we ? web : 4'b1111;
        mem_valid = 1'b1; mem_we = we; funct3 = f3; addr = a; st_web = web; st_wdata = wd;
        dm_rdata = rdata;
        for (int cyc = 0; cyc < 60; cyc++) begin
            dm_gnt = 1'b0;
            dm_rvalid = 1'b0;
            if (dm_req) begin
                req_cyc++;
                if (dm_addr !== exp_addr || dm_web !== exp_web || (we && dm_wdata !== wd))
                    req_bad++;
                dm_gnt = (req_cyc > gnt_wait);
            end
            if (in_resp) begin
                resp_cyc++;
                dm_rvalid = (resp_cyc > rv_wait);
            end
            #1;
            if (!stall) begin
                done_lv = ld_valid;
                done_mx = misalign_exc;
                done_to = 0;
                tick();
                break;
            end
            stall_cyc++;
            if (dm_gnt && !we) in_resp = 1;
            if (dm_rvalid) in_resp = 0;
            tick();
        end
        dm_gnt = 1'b0;
        dm_rvalid = 1'b0;
    endtask

    int   sc, rc, rb, lv0, g0;
    logic lv, mx, to;

    initial begin
        rst_n = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; funct3 = 3'b000; addr = '0;
        st_web = 4'b1111; st_wdata = '0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_dm_req", {31'd0, dm_req}, 32'd0);
        chk("reset_dm_web", {28'd0, dm_web}, 32'h0000000F);
        chk("reset_ld_data", ld_data, 32'h0);
        tick();

        // SW 0x100
        do_access(1'b1, 3'b010, 32'h100, 4'b0000, 32'hDEADBEEF, 0, 0, 32'h0, sc, rc, rb, lv, mx, to);
        chk("sw_timeout", {31'd0, to}, 32'd0);
        chk("sw_stall_cycles", sc, 32'd2);
        chk("sw_req_cycles", rc, 32'd1);
        chk("sw_req_fields_bad", rb, 32'd0);
        chk("sw_ld_valid", {31'd0, lv}, 32'd0);
        chk("sw_dm_addr", dm_addr, 32'h100);
        chk("sw_dm_web", {28'd0, dm_web}, 32'h0);
        chk("sw_dm_wdata", dm_wdata, 32'hDEADBEEF);
        chk("sw_dm_req_after_gnt", {31'd0, dm_req}, 32'd0);
        mem_valid = 1'b0;

        // LB 0x203
        do_access(1'b0, 3'b000, 32'h203, 4'b1111, 32'h0, 0, 2, 32'h80FF1234, sc, rc, rb, lv, mx, to);
        chk("lb_stall_cycles", sc, 32'd5);
        chk("lb_ld_valid", {31'd0, lv}, 32'd1);
        chk("lb_ld_data", ld_data, 32'hFFFFFF80);
        chk("lb_req_fields_bad", rb, 32'd0);
        chk("lb_ld_valid_pulse", {31'd0, ld_valid}, 32'd0);

        // LBU 0x203
        do_access(1'b0, 3'b100, 32'h203, 4'b1111, 32'h0, 0, 2, 32'h80FF1234, sc, rc, rb, lv, mx, to);
        chk("lbu_ld_data", ld_data, 32'h00000080);
        chk("lbu_ld_valid", {31'd0, lv}, 32'd1);

        // LHU 0x302, LH 0x302 (negative half), LW 0x400
        do_access(1'b0, 3'b101, 32'h302, 4'b1111, 32'h0, 1, 0, 32'hBEEF0000, sc, rc, rb, lv, mx, to);
        chk("lhu_ld_data", ld_data, 32'h0000BEEF);
        chk("lhu_stall_cycles", sc, 32'd4);
        do_access(1'b0, 3'b001, 32'h302, 4'b1111, 32'h0, 0, 0, 32'h80011234, sc, rc, rb, lv, mx, to);
        chk("lh_ld_data", ld_data, 32'hFFFF8001);
        do_access(1'b0, 3'b010, 32'h400, 4'b1111, 32'h0, 0, 0, 32'hCAFEF00D, sc, rc, rb, lv, mx, to);
        chk("lw_ld_data", ld_data, 32'hCAFEF00D);
        chk("lw_stall_cycles", sc, 32'd3);

        // Misaligned LH 0x301 and SW 0x102
        do_access(1'b0, 3'b001, 32'h301, 4'b1111, 32'h0, 0, 0, 32'h0, sc, rc, rb, lv, mx, to);
        chk("lh_mis_exc", {31'd0, mx}, 32'd1);
        chk("lh_mis_req_cycles", rc, 32'd0);
        chk("lh_mis_stall_cycles", sc, 32'd1);
        chk("lh_mis_ld_valid", {31'd0, lv}, 32'd0);
        chk("lh_mis_ld_data_held", ld_data, 32'hCAFEF00D);
        do_access(1'b1, 3'b010, 32'h102, 4'b0000, 32'h1, 0, 0, 32'h0, sc, rc, rb, lv, mx, to);
        chk("sw_mis_exc", {31'd0, mx}, 32'd1);
        chk("sw_mis_req_cycles", rc, 32'd0);
        chk("exc_pulse", {31'd0, misalign_exc}, 32'd0);

        // SB 0x3 with gnt withheld 4 cycles
        do_access(1'b1, 3'b000, 32'h3, 4'b0111, 32'h55555555, 4, 0, 32'h0, sc, rc, rb, lv, mx, to);
        chk("sb_req_cycles", rc, 32'd5);
        chk("sb_req_fields_bad", rb, 32'd0);
        chk("sb_stall_cycles", sc, 32'd6);
        chk("sb_dm_addr", dm_addr, 32'h0);

        // Store with no lanes enabled, undefined funct3
        do_access(1'b1, 3'b111, 32'h44, 4'b1111, 32'h12345678, 0, 0, 32'h0, sc, rc, rb, lv, mx, to);
        chk("noop_req_cycles", rc, 32'd0);
        chk("noop_stall_cycles", sc, 32'd1);
        chk("noop_exc", {31'd0, mx}, 32'd0);

        // Back-to-back loads, mem_valid never drops
        lv0 = ld_valid_cnt; g0 = grant_cnt;
        do_access(1'b0, 3'b010, 32'h500, 4'b1111, 32'h0, 0, 0, 32'h11223344, sc, rc, rb, lv, mx, to);
        chk("b2b_first_data", ld_data, 32'h11223344);
        do_access(1'b0, 3'b100, 32'h501, 4'b1111, 32'h0, 0, 1, 32'h0000A500, sc, rc, rb, lv, mx, to);
        chk("b2b_second_data", ld_data, 32'h000000A5);
        mem_valid = 1'b0;
        tick(); tick();
        chk("b2b_grants", grant_cnt - g0, 32'd2);
        chk("b2b_ld_valids", ld_valid_cnt - lv0, 32'd2);

        // Reset during RESP, late rvalid afterwards
        lv0 = ld_valid_cnt;
        mem_valid = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h600; dm_rdata = 32'h77777777;
        tick();
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0; mem_valid = 1'b0;
        chk("rst_in_resp_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dm_rvalid = 1'b1;
        tick();
        tick();
        dm_rvalid = 1'b0;
        chk("rst_ld_valid_none", ld_valid_cnt - lv0, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_web", {28'd0, dm_web}, 32'h0000000F);
        chk("rst_dm_wdata", dm_wdata, 32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_exc", {31'd0, misalign_exc}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- Memory-access sequencer directly downstream of the store byte-lane formatter.
- Accepts one load or store per MEM-stage instruction and drives the data-memory port with a req/gnt/rvalid handshake.
- Stalls the pipeline until the access completes, then returns aligned, sign- or zero-extended load data to writeback.
- Flags misaligned accesses instead of issuing them.

Parameters:
ADDR_W, 32, address width (fixed for RV32; other values unsupported)
DATA_W, 32, data word width (fixed for RV32)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous active-low reset
mem_valid  in  1  MEM stage holds a load/store this cycle
mem_we  in  1  1 = store, 0 = load
funct3  in  3  RV32 load/store funct3
addr  in  32  byte address (ALU result)
st_web  in  4  active-low byte write enables from the store formatter
st_wdata  in  32  lane-replicated store data from the store formatter
stall  out  1  hold IF/ID/EX/MEM registers
ld_data  out  32  extended load result
ld_valid  out  1  one-cycle pulse: ld_data updated
misalign_exc  out  1  one-cycle pulse: access rejected
dm_req  out  1  memory request
dm_gnt  in  1  request accepted this cycle
dm_addr  out  32  word address {addr[31:2],2'b00}
dm_web  out  4  active-low byte enables; 4'b1111 for reads
dm_wdata  out  32  store data
dm_rvalid  in  1  read data valid
dm_rdata  in  32  read word

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE. dm_req=0, dm_addr=0, dm_web=4'b1111, dm_wdata=0, ld_data=0, ld_valid=0, misalign_exc=0. Any in-flight access is abandoned.
- FSM states: IDLE, REQ, RESP, DONE. All dm_* outputs and ld_* outputs are registered.
- stall = (IDLE & mem_valid) | REQ | RESP. stall=0 in DONE.
- IDLE, mem_valid=1: capture addr, funct3, mem_we, st_web, st_wdata. Next state:
  - misaligned → DONE with misalign_exc=1.
  - store with st_web==4'b1111 → DONE as a no-op; no dm_req.
  - otherwise → REQ.
- Misaligned means:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
  - Byte accesses never misalign.
- REQ: dm_req=1. dm_addr, dm_web and dm_wdata stay stable until dm_gnt.
  - Reads drive dm_web=4'b1111.
  - Store + dm_gnt → DONE.
  - Load + dm_gnt → RESP.
  - dm_req deasserts the cycle after gnt.
- RESP: wait on dm_rvalid. On dm_rvalid, register the extracted data into ld_data → DONE with ld_valid=1. dm_rvalid is ignored in every other state.
- Extraction, byte lane = addr[1:0]:
  - LB (000): sign-extend the byte.
  - LBU (100): zero-extend the byte.
  - LH (001): sign-extend the halfword selected by addr[1].
  - LHU (101): zero-extend that halfword.
  - LW (010) and any other funct3: full word.
- DONE: lasts exactly one cycle, then → IDLE.
  - The pipeline advances at this edge.
  - mem_valid is not sampled in DONE, so the same instruction is never re-issued.
- ld_data holds its value until the next load completes.
- mem_valid in REQ/RESP/DONE is ignored; the captured request is authoritative.
- Minimum latency: store 3 cycles (IDLE→REQ→DONE); load 4 cycles (IDLE→REQ→RESP→DONE). The memory may stretch either by withholding gnt or rvalid; there is no timeout.
- rst_n=0 during REQ/RESP: the next state is IDLE. Late gnt/rvalid from the abandoned access must not produce ld_valid.

Decomposition:
- cpu_pkg holds:
  - funct3 localparams: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - dm_state_t enum: IDLE, REQ, RESP, DONE.
  - WEB_NONE = 4'b1111.
- One combinational sub-module, load_align (funct3, byte_off, rdata → ext_data), instantiated in RESP capture. The misalignment check stays inline.

Test Plan:
- SW addr=0x100, st_web=0000, st_wdata=0xDEADBEEF, gnt on first REQ cycle → dm_addr=0x100, dm_web=0000, stall high 2 cycles, low in DONE, no ld_valid.
- LB addr=0x203, dm_rdata=0x80FF_1234, rvalid 2 cycles after gnt → ld_data=0xFFFFFF80, ld_valid pulse, stall high 5 cycles total. Repeat as LBU → 0x00000080.
- LHU addr=0x302, dm_rdata=0xBEEF_0000 → ld_data=0x0000BEEF. LH at addr=0x301 → misalign_exc pulse, dm_req never asserted, stall 1 cycle.
- SB addr=0x3 with gnt withheld 4 cycles → dm_req/dm_addr/dm_web=0111 stable all 5 REQ cycles, DONE follows the gnt cycle.
- Store with st_web=1111 (undefined funct3) → no dm_req, DONE after 1 stall cycle. Back-to-back loads with mem_valid held high → exactly one access per instruction.
- rst_n=0 while in RESP, then rvalid arrives → state IDLE, ld_valid stays 0, all outputs at reset values.
